// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with double-buffered value,
// leading-zero blanking and floating minus. Optional hex glyphs: SEG7_HEX_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  neg_in,
  input  logic                  blank_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned IDXW = $clog2(DIGITS);
  localparam int unsigned PCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  logic [PCW-1:0]       pc_q, pc_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]  sh_dig_q, sh_dig_d;
  logic                 sh_neg_q, sh_neg_d;
  logic                 sh_blank_q, sh_blank_d;
  logic [4*DIGITS-1:0]  act_dig_q, act_dig_d;
  logic                 act_neg_q, act_neg_d;
  logic                 act_blank_q, act_blank_d;
  logic                 pending_q, pending_d;
  logic                 wrap_q, wrap_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;

  logic                 pc_term;
  logic [IDXW-1:0]      k_c;
  logic [3:0]           cur_nib;
  logic                 nonzero;
  logic                 show_minus;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
`endif
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Scan timing, double buffer and commit
  always_comb begin
    pc_term     = (pc_q == PCW'(REFRESH_DIV - 1));
    pc_d        = pc_term ? '0 : pc_q + PCW'(1);
    idx_d       = idx_q;
    wrap_d      = pc_term && (idx_q == IDXW'(DIGITS - 1));
    if (pc_term) begin
      idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end
    frame_tick_d = wrap_q;

    // On a wrap+load collision the old shadow commits while the new value
    // lands in the shadow, so pending stays set.
    act_dig_d   = wrap_d ? sh_dig_q   : act_dig_q;
    act_neg_d   = wrap_d ? sh_neg_q   : act_neg_q;
    act_blank_d = wrap_d ? sh_blank_q : act_blank_q;
    sh_dig_d    = load ? digits_in : sh_dig_q;
    sh_neg_d    = load ? neg_in    : sh_neg_q;
    sh_blank_d  = load ? blank_en  : sh_blank_q;
    pending_d   = load ? 1'b1 : (wrap_d ? 1'b0 : pending_q);
  end

  // Glyph selection for the position currently being scanned
  always_comb begin
    k_c     = '0;
    cur_nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (act_dig_q[4*i +: 4] != 4'd0) k_c = IDXW'(i);
      if (IDXW'(i) == idx_q) cur_nib = act_dig_q[4*i +: 4];
    end
    nonzero    = |act_dig_q;
    show_minus = 1'b0;
    if (act_neg_q && nonzero) begin
      if (act_blank_q) begin
        show_minus = (({1'b0, k_c} + 1'b1) == {1'b0, idx_q});
      end else begin
        show_minus = (idx_q == IDXW'(DIGITS - 1)) &&
                     (act_dig_q[4*DIGITS-1 -: 4] == 4'd0);
      end
    end

    if (show_minus) begin
      seg_d = GLYPH_MINUS;
    end else if (act_blank_q && (idx_q > k_c)) begin
      seg_d = GLYPH_BLANK;
    end else begin
      seg_d = glyph(cur_nib);
    end
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      idx_q        <= '0;
      sh_dig_q     <= '0;
      sh_neg_q     <= 1'b0;
      sh_blank_q   <= 1'b0;
      act_dig_q    <= '0;
      act_neg_q    <= 1'b0;
      act_blank_q  <= 1'b0;
      pending_q    <= 1'b0;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= '1;
      an_q         <= '1;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      sh_dig_q     <= sh_dig_d;
      sh_neg_q     <= sh_neg_d;
      sh_blank_q   <= sh_blank_d;
      act_dig_q    <= act_dig_d;
      act_neg_q    <= act_neg_d;
      act_blank_q  <= act_blank_d;
      pending_q    <= pending_d;
      wrap_q       <= wrap_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule
